mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single main-memory port between the instruction-cache refill path and the data-cache path (block refills and write-through stores). It sequences multi-beat block reads and single-beat writes, returns read beats to the owning requester, and signals completion so each cache can release the core `stall`. The block sits between the two cache controllers and the main-memory model, below the RISC-V core.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, word width; fixed at 32 (4-byte words)
- `BLOCK_WORDS`, 4, words per cache block; power of two, 2..16

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_req`  in  1  I-side block-read request; held until `i_done`
- `i_addr`  in  ADDR_W  I-side miss address; low bits ignored (block-aligned internally)
- `i_rvalid`  out  1  I-side read beat valid
- `i_rdata`  out  DATA_W  I-side read beat data
- `i_done`  out  1  one-cycle pulse on final I-side beat
- `d_req`  in  1  D-side request; held, with all D-side inputs stable, until `d_done`
- `d_we`  in  1  1 = single-word write, 0 = block read
- `d_addr`  in  ADDR_W  D-side address
- `d_wdata`  in  DATA_W  write data
- `d_be`  in  4  byte enables for writes (derived from Storetype)
- `d_rvalid`  out  1  D-side read beat valid
- `d_rdata`  out  DATA_W  D-side read beat data
- `d_done`  out  1  one-cycle pulse on final D-side beat
- `mem_req`  out  1  memory beat request
- `mem_we`  out  1  memory write
- `mem_addr`  out  ADDR_W  word address of current beat
- `mem_wdata`  out  DATA_W  write data
- `mem_be`  out  4  byte enables
- `mem_ready`  in  1  current beat completes this cycle; read data valid this cycle
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- States: IDLE, GRANT_I, GRANT_D. Registers: state, `beat` counter (log2(BLOCK_WORDS) bits), `last_grant` (I or D).
- IDLE: only `d_req` -> GRANT_D; only `i_req` -> GRANT_I; both -> grant the side not in `last_grant` (round-robin). `last_grant` updates on entry to a grant state. `beat` cleared on entry.
- GRANT_x: `mem_req`=1 every cycle. Read: `mem_addr` = block base of x_addr with word index = `beat`, bits [1:0]=0; `mem_we`=0; `mem_be`=4'hF. Write (GRANT_D, `d_we`=1): `mem_addr`={`d_addr`[ADDR_W-1:2],2'b00}, `mem_we`=1, `mem_wdata`=`d_wdata`, `mem_be`=`d_be`; one beat only.
- On `mem_ready` in GRANT_x read: x_rvalid=1, x_rdata=`mem_rdata` (combinational); `beat` increments. Beat index order 0..BLOCK_WORDS-1, no critical-word-first, no wrap.
- Final beat (read: `beat`=BLOCK_WORDS-1; write: first beat) with `mem_ready`: x_done=1 same cycle; next state IDLE.
- Requester drops req the cycle after done; any req seen in IDLE is a new request. Non-owner requests wait; non-owner outputs stay 0.
- `mem_ready` in IDLE is ignored. In IDLE all `mem_*` outputs are 0.
- `i_rdata`/`d_rdata` are 0 whenever the matching rvalid is 0.

## Timing
- Reset: state IDLE, `beat`=0, `last_grant`=I (first tie goes to D); all outputs 0 the cycle after `rst` sampled high.
- Reset mid-transaction: aborted immediately; no done pulse; `mem_req`=0 next cycle; memory tolerates abandoned beats.
- Latency: req sampled in IDLE at edge N -> `mem_req`=1 in cycle N+1. Block read with memory latency L cycles per beat ends BLOCK_WORDS*L cycles after grant; done coincides with last `mem_ready`.
- One mandatory IDLE bubble between transactions; back-to-back requests alternate I/D when both pending.
- Starvation bound: a pending requester is granted after at most one transaction of the other side.

## Test plan
- Reset: assert `rst` 2 cycles while `i_req`=1 -> all outputs 0; release -> GRANT_I, `mem_req`=1 next cycle.
- I-side refill, `i_addr`=0x0000_1234, `mem_ready` every other cycle -> `mem_addr` 0x1230,0x1234,0x1238,0x123C; 4 `i_rvalid` pulses carrying `mem_rdata`; `i_done` on 4th only.
- D-side write, `d_addr`=0x0000_2006, `d_be`=4'b1100, `d_wdata`=0xDEADBEEF -> `mem_we`=1, `mem_addr`=0x2004, `mem_be`=4'b1100; `d_done` on first `mem_ready`; `d_rvalid` never set.
- Simultaneous `i_req`/`d_req` after reset, both held re-requesting -> grant order D, I, D, I with one IDLE cycle between.
- `rst` pulse after 2 of 4 beats of a D read -> no `d_done`; IDLE; new `d_req` restarts at beat 0 (block base address).
- `mem_ready` toggling while IDLE and spurious `i_req` during GRANT_D -> no rvalid/done to either side; I granted after D completes.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache-side request channels and the main-memory beat port.
//
// Handshake semantics, for every channel in this bundle:
//   - A cache raises x_req and holds it, with all of its x_* inputs stable,
//     until the arbiter pulses x_done. It lowers x_req the cycle after x_done.
//     A request seen while the arbiter is idle is always a new transaction.
//   - One memory beat is in flight whenever mem_req=1. It completes in the
//     cycle where mem_ready=1; read data on mem_rdata is valid only then.
//     mem_ready is ignored while mem_req=0.
//   - x_rvalid marks a read beat for the owning side in the same cycle it
//     completes. x_rdata is zero whenever x_rvalid is zero.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ready, mem_rdata,
    output i_rvalid, i_rdata, i_done, d_rvalid, d_rdata, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Environment side: the two caches plus the memory model.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ready, mem_rdata,
    input  i_rvalid, i_rdata, i_done, d_rvalid, d_rdata, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between the I-cache refill path and the
// D-cache path. Block reads are issued as BLOCK_WORDS sequential beats from
// the block base; D-side writes are a single beat. Ties are broken
// round-robin so neither side waits longer than one transaction of the other.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           dbg_state
);

  localparam int              BW        = $clog2(BLOCK_WORDS);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] beat;
  logic          last_grant_d;  // 0: last grant went to I, 1: to D

  // Word address of a read beat: block base of the request plus beat index.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [BW-1:0]     b);
    beat_addr = {a[ADDR_W-1:BW+2], b, 2'b00};
  endfunction

  assign dbg_state = state;

  // State, beat counter and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      last_grant_d <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        beat <= '0;
        if (state_n == GRANT_I) begin
          last_grant_d <= 1'b0;
        end else if (state_n == GRANT_D) begin
          last_grant_d <= 1'b1;
        end
      end else if (bus.mem_ready) begin
        beat <= beat + BW'(1);
      end
    end
  end

  // Grant selection, memory beat drive and return-path steering.
  always_comb begin
    state_n       = state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = 4'h0;
    bus.i_rvalid  = 1'b0;
    bus.i_rdata   = '0;
    bus.i_done    = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = '0;
    bus.d_done    = 1'b0;

    case (state)
      IDLE: begin
        // On a tie, serve the side that was not granted last.
        if (bus.d_req && (!bus.i_req || !last_grant_d)) begin
          state_n = GRANT_D;
        end else if (bus.i_req) begin
          state_n = GRANT_I;
        end
      end

      GRANT_I: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = beat_addr(bus.i_addr, beat);
        bus.mem_be   = 4'hF;
        if (bus.mem_ready) begin
          bus.i_rvalid = 1'b1;
          bus.i_rdata  = bus.mem_rdata;
          if (beat == LAST_BEAT) begin
            bus.i_done = 1'b1;
            state_n    = IDLE;
          end
        end
      end

      GRANT_D: begin
        bus.mem_req = 1'b1;
        if (bus.d_we) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = {bus.d_addr[ADDR_W-1:2], 2'b00};
          bus.mem_wdata = bus.d_wdata;
          bus.mem_be    = bus.d_be;
          if (bus.mem_ready) begin
            bus.d_done = 1'b1;
            state_n    = IDLE;
          end
        end else begin
          bus.mem_addr = beat_addr(bus.d_addr, beat);
          bus.mem_be   = 4'hF;
          if (bus.mem_ready) begin
            bus.d_rvalid = 1'b1;
            bus.d_rdata  = bus.mem_rdata;
            if (beat == LAST_BEAT) begin
              bus.d_done = 1'b1;
              state_n    = IDLE;
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
